// File: rtl/axil_periph_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers with byte strobes.
// Independent AW/W holding buffers feed a two-state write FSM; reads return in one cycle.
`timescale 1ns/1ps

module axil_periph_slave #(
   parameter int unsigned NUM_REGS  = 16,
   parameter logic [31:0] RESET_VAL = 32'h0
) (
   input  logic                     clk,
   input  logic                     rstf,
   // write address
   input  logic [31:0]              s_axi_awaddr,
   input  logic [2:0]               s_axi_awprot,
   input  logic                     s_axi_awvalid,
   output logic                     s_axi_awready,
   // write data
   input  logic [31:0]              s_axi_wdata,
   input  logic [3:0]               s_axi_wstrb,
   input  logic                     s_axi_wvalid,
   output logic                     s_axi_wready,
   // write response
   output logic [1:0]               s_axi_bresp,
   output logic                     s_axi_bvalid,
   input  logic                     s_axi_bready,
   // read address
   input  logic [31:0]              s_axi_araddr,
   input  logic [2:0]               s_axi_arprot,
   input  logic                     s_axi_arvalid,
   output logic                     s_axi_arready,
   // read data
   output logic [31:0]              s_axi_rdata,
   output logic [1:0]               s_axi_rresp,
   output logic                     s_axi_rvalid,
   input  logic                     s_axi_rready,
   // register file view
   output logic [NUM_REGS*32-1:0]   regs_q,
   output logic [NUM_REGS-1:0]      wr_pulse
);

   localparam int unsigned IW = $clog2(NUM_REGS);
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic {WR_COLLECT, WR_RESP} wr_state_t;

   // Any address bit above the word index makes the access out-of-range.
   function automatic logic addr_oor(input logic [31:0] a);
      return (a >> (2 + IW)) != 32'd0;
   endfunction

   function automatic logic [IW-1:0] addr_idx(input logic [31:0] a);
      return a[2 +: IW];
   endfunction

   wr_state_t                   wr_state_q, wr_state_d;
   logic                        aw_full_q,  aw_full_d;
   logic [IW-1:0]               aw_idx_q,   aw_idx_d;
   logic                        aw_oor_q,   aw_oor_d;
   logic                        w_full_q,   w_full_d;
   logic [31:0]                 wdata_q,    wdata_d;
   logic [3:0]                  wstrb_q,    wstrb_d;
   logic                        bvalid_q,   bvalid_d;
   logic [1:0]                  bresp_q,    bresp_d;
   logic [NUM_REGS-1:0][31:0]   reg_arr_q,  reg_arr_d;
   logic [NUM_REGS-1:0]         pulse_q,    pulse_d;
   logic                        rvalid_q,   rvalid_d;
   logic [31:0]                 rdata_q,    rdata_d;
   logic [1:0]                  rresp_q,    rresp_d;

   logic aw_hs, w_hs, ar_hs, commit;
   logic unused_prot;

   assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

   assign s_axi_awready = !aw_full_q && !bvalid_q;
   assign s_axi_wready  = !w_full_q  && !bvalid_q;
   assign s_axi_arready = !rvalid_q;

   assign aw_hs = s_axi_awvalid && s_axi_awready;
   assign w_hs  = s_axi_wvalid  && s_axi_wready;
   assign ar_hs = s_axi_arvalid && s_axi_arready;

   // Write channel buffers and response FSM
   always_comb begin
      wr_state_d = wr_state_q;
      aw_full_d  = aw_full_q;
      aw_idx_d   = aw_idx_q;
      aw_oor_d   = aw_oor_q;
      w_full_d   = w_full_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      commit     = 1'b0;

      if (aw_hs) begin
         aw_full_d = 1'b1;
         aw_idx_d  = addr_idx(s_axi_awaddr);
         aw_oor_d  = addr_oor(s_axi_awaddr);
      end
      if (w_hs) begin
         w_full_d = 1'b1;
         wdata_d  = s_axi_wdata;
         wstrb_d  = s_axi_wstrb;
      end

      // Commit only ever sees full buffers, so it never collides with a fill.
      case (wr_state_q)
         WR_COLLECT: begin
            if (aw_full_q && w_full_q) begin
               commit     = 1'b1;
               aw_full_d  = 1'b0;
               w_full_d   = 1'b0;
               bvalid_d   = 1'b1;
               bresp_d    = aw_oor_q ? RESP_SLVERR : RESP_OKAY;
               wr_state_d = WR_RESP;
            end
         end
         WR_RESP: begin
            if (s_axi_bready) begin
               bvalid_d   = 1'b0;
               wr_state_d = WR_COLLECT;
            end
         end
         default: wr_state_d = WR_COLLECT;
      endcase
   end

   // Register file update with byte strobes
   always_comb begin
      reg_arr_d = reg_arr_q;
      pulse_d   = '0;
      if (commit && !aw_oor_q) begin
         pulse_d[aw_idx_q] = 1'b1;
         for (int k = 0; k < 4; k++) begin
            if (wstrb_q[k]) reg_arr_d[aw_idx_q][8*k +: 8] = wdata_q[8*k +: 8];
         end
      end
   end

   // Read path samples the pre-commit register value on a same-edge write.
   always_comb begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         if (addr_oor(s_axi_araddr)) begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
         end else begin
            rdata_d = reg_arr_q[addr_idx(s_axi_araddr)];
            rresp_d = RESP_OKAY;
         end
      end else if (rvalid_q && s_axi_rready) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstf) begin
      if (!rstf) begin
         wr_state_q <= WR_COLLECT;
         aw_full_q  <= 1'b0;
         aw_idx_q   <= '0;
         aw_oor_q   <= 1'b0;
         w_full_q   <= 1'b0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         reg_arr_q  <= {NUM_REGS{RESET_VAL}};
         pulse_q    <= '0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
      end else begin
         wr_state_q <= wr_state_d;
         aw_full_q  <= aw_full_d;
         aw_idx_q   <= aw_idx_d;
         aw_oor_q   <= aw_oor_d;
         w_full_q   <= w_full_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         reg_arr_q  <= reg_arr_d;
         pulse_q    <= pulse_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
      end
   end

   assign s_axi_bvalid = bvalid_q;
   assign s_axi_bresp  = bresp_q;
   assign s_axi_rvalid = rvalid_q;
   assign s_axi_rdata  = rdata_q;
   assign s_axi_rresp  = rresp_q;
   assign regs_q       = reg_arr_q;
   assign wr_pulse     = pulse_q;

endmodule
